// File: rtl/fe_fetch_if.sv
// Fetch-unit bus: ROM read port, backend redirect and decode handshake.
// master = fetch unit, slave = ROM/backend/decode side.
interface fe_fetch_if #(
  parameter int ADDR_W = 1,
  parameter int WORD_W = 1
);
  logic [ADDR_W-1:0] rom_addr_o;
  logic [WORD_W-1:0] rom_data_i;
  logic              redirect_v_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              fetch_v_o;
  logic [WORD_W-1:0] fetch_instr_o;
  logic [ADDR_W-1:0] fetch_pc_o;
  logic              fetch_ready_i;

  modport master (
    output rom_addr_o,
    input  rom_data_i,
    input  redirect_v_i,
    input  redirect_pc_i,
    output fetch_v_o,
    output fetch_instr_o,
    output fetch_pc_o,
    input  fetch_ready_i
  );

  modport slave (
    input  rom_addr_o,
    output rom_data_i,
    output redirect_v_i,
    output redirect_pc_i,
    input  fetch_v_o,
    input  fetch_instr_o,
    input  fetch_pc_o,
    output fetch_ready_i
  );
endinterface

// File: rtl/fe_fetch.sv
// Instruction fetch stage: PC register driving an async ROM, buffered in a
// small {instr,pc} FIFO; ports: clk_i, reset_n_i (sync, active-low), bus.
module fe_fetch #(
  parameter int I_CACHE_DEPTH_P = -1,
  parameter int WORD_SIZE_P     = -1,
  parameter int FIFO_DEPTH_P    = 2
) (
  input logic        clk_i,
  input logic        reset_n_i,
  fe_fetch_if.master bus
);
  localparam int ADDR_WIDTH_LP = $clog2(I_CACHE_DEPTH_P);
  localparam int PW = $clog2(FIFO_DEPTH_P);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [WORD_SIZE_P-1:0]   instr;
    logic [ADDR_WIDTH_LP-1:0] pc;
  } entry_t;

  entry_t mem [FIFO_DEPTH_P];

  logic [ADDR_WIDTH_LP-1:0] pc_q;
  logic [PW-1:0]            head_q;
  logic [PW-1:0]            tail_q;
  logic [CW-1:0]            count_q;

  logic full;
  logic deq;
  logic enq;

  // A full buffer may still accept when decode frees the head this cycle.
  always_comb begin
    full = (count_q == CW'(FIFO_DEPTH_P));
    deq  = (count_q != '0) & bus.fetch_ready_i;
    enq  = ~bus.redirect_v_i & (~full | deq);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pc_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.redirect_v_i) begin
      pc_q    <= bus.redirect_pc_i;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        pc_q   <= pc_q + ADDR_WIDTH_LP'(1);
        tail_q <= tail_q + PW'(1);
      end
      if (deq) begin
        head_q <= head_q + PW'(1);
      end
      unique case ({enq, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && enq) begin
      mem[tail_q] <= '{instr: bus.rom_data_i, pc: pc_q};
    end
  end

  assign bus.rom_addr_o    = pc_q;
  assign bus.fetch_v_o     = (count_q != '0);
  assign bus.fetch_instr_o = mem[head_q].instr;
  assign bus.fetch_pc_o    = mem[head_q].pc;
endmodule

// File: tb/tb_fe_fetch.sv
// Bench for fe_fetch: directed scenarios plus randomized traffic checked
// against a queue-based model of the fetch buffer.
module tb_fe_fetch;
  localparam int DEPTH = 64;
  localparam int W     = 32;
  localparam int F     = 2;
  localparam int AW    = $clog2(DEPTH);

  logic clk;
  logic reset_n;
  logic [W-1:0] rom [DEPTH];

  int checks;
  int failures;

  int q[$];
  int npc;

  fe_fetch_if #(.ADDR_W(AW), .WORD_W(W)) bus ();

  fe_fetch #(
    .I_CACHE_DEPTH_P(DEPTH),
    .WORD_SIZE_P(W),
    .FIFO_DEPTH_P(F)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .bus(bus)
  );

  assign bus.rom_data_i = rom[bus.rom_addr_o];

  initial clk = 0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance model across the edge, settle.
  task automatic step(bit rv, int rpc, bit rdy, bit rstn);
    bit deq;
    bit enq;
    bus.redirect_v_i  = rv;
    bus.redirect_pc_i = AW'(rpc);
    bus.fetch_ready_i = rdy;
    reset_n           = rstn;
    @(posedge clk);
    if (!rstn) begin
      q.delete();
      npc = 0;
    end else begin
      deq = (q.size() > 0) && rdy;
      enq = !rv && ((q.size() < F) || deq);
      if (rv) begin
        q.delete();
        npc = rpc;
      end else begin
        if (deq) void'(q.pop_front());
        if (enq) begin
          q.push_back(npc);
          npc = (npc + 1) % DEPTH;
        end
      end
    end
    #1;
  endtask

  task automatic rom_identity();
    for (int i = 0; i < DEPTH; i++) rom[i] = W'(i);
  endtask

  task automatic test_reset();
    rom_identity();
    for (int i = 0; i < 2; i++) begin
      step(1, 5, 1, 0);
      checks++;
      if (bus.fetch_v_o !== 1'b0 || bus.rom_addr_o !== '0) begin
        failures++;
        $display("FAIL reset_hold v=%b addr=%0d want v=0 addr=0",
                 bus.fetch_v_o, bus.rom_addr_o);
      end
    end
    reset_n = 1;
    #1;
    checks++;
    if (bus.fetch_v_o !== 1'b0 || bus.rom_addr_o !== '0) begin
      failures++;
      $display("FAIL reset_release v=%b addr=%0d want v=0 addr=0",
               bus.fetch_v_o, bus.rom_addr_o);
    end
  endtask

  task automatic test_stream();
    rom_identity();
    step(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 1);
      checks++;
      if (bus.fetch_v_o !== 1'b1 || bus.fetch_pc_o !== AW'(i) ||
          bus.fetch_instr_o !== W'(i)) begin
        failures++;
        $display("FAIL stream[%0d] v=%b pc=%0d instr=%0d want v=1 pc=%0d",
                 i, bus.fetch_v_o, bus.fetch_pc_o, bus.fetch_instr_o, i);
      end
    end
  endtask

  task automatic test_stall();
    rom_identity();
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    checks++;
    if (bus.fetch_v_o !== 1'b1 || bus.fetch_pc_o !== AW'(0) ||
        bus.rom_addr_o !== AW'(2)) begin
      failures++;
      $display("FAIL stall_hold v=%b pc=%0d addr=%0d want v=1 pc=0 addr=2",
               bus.fetch_v_o, bus.fetch_pc_o, bus.rom_addr_o);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.fetch_v_o !== 1'b1 || bus.fetch_pc_o !== AW'(k)) begin
        failures++;
        $display("FAIL stall_drain[%0d] v=%b pc=%0d want v=1 pc=%0d",
                 k, bus.fetch_v_o, bus.fetch_pc_o, k);
      end
      step(0, 0, 1, 1);
    end
  endtask

  task automatic test_redirect_full();
    rom_identity();
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    step(1, 'h10, 1, 1);
    checks++;
    if (bus.fetch_v_o !== 1'b0) begin
      failures++;
      $display("FAIL redir_bubble v=%b want 0", bus.fetch_v_o);
    end
    step(0, 0, 1, 1);
    checks++;
    if (bus.fetch_v_o !== 1'b1 || bus.fetch_pc_o !== AW'('h10) ||
        bus.fetch_instr_o !== W'('h10)) begin
      failures++;
      $display("FAIL redir_target v=%b pc=%0h instr=%0h want v=1 pc=10",
               bus.fetch_v_o, bus.fetch_pc_o, bus.fetch_instr_o);
    end
  endtask

  task automatic test_wrap();
    int exp_pc [3];
    exp_pc = '{DEPTH - 1, 0, 1};
    rom_identity();
    step(1, DEPTH - 1, 1, 1);
    checks++;
    if (bus.fetch_v_o !== 1'b0) begin
      failures++;
      $display("FAIL wrap_bubble v=%b want 0", bus.fetch_v_o);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1);
      checks++;
      if (bus.fetch_v_o !== 1'b1 || bus.fetch_pc_o !== AW'(exp_pc[i])) begin
        failures++;
        $display("FAIL wrap[%0d] v=%b pc=%0d want v=1 pc=%0d",
                 i, bus.fetch_v_o, bus.fetch_pc_o, exp_pc[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    rom_identity();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
    step(1, 4, 1, 1);
    step(1, 8, 1, 1);
    checks++;
    if (bus.fetch_v_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_bubble v=%b want 0", bus.fetch_v_o);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1);
      checks++;
      if (bus.fetch_v_o !== 1'b1 || bus.fetch_pc_o !== AW'(8 + i)) begin
        failures++;
        $display("FAIL b2b[%0d] v=%b pc=%0d want v=1 pc=%0d",
                 i, bus.fetch_v_o, bus.fetch_pc_o, 8 + i);
      end
    end
  endtask

  task automatic test_mid_reset();
    rom_identity();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    step(1, 'h20, 1, 0);
    checks++;
    if (bus.fetch_v_o !== 1'b0 || bus.rom_addr_o !== '0) begin
      failures++;
      $display("FAIL mrst_hold v=%b addr=%0d want v=0 addr=0",
               bus.fetch_v_o, bus.rom_addr_o);
    end
    reset_n = 1;
    bus.redirect_v_i = 0;
    #1;
    checks++;
    if (bus.fetch_v_o !== 1'b0) begin
      failures++;
      $display("FAIL mrst_release v=%b want 0", bus.fetch_v_o);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, 1);
      checks++;
      if (bus.fetch_v_o !== 1'b1 || bus.fetch_pc_o !== AW'(i)) begin
        failures++;
        $display("FAIL mrst_restart[%0d] v=%b pc=%0d want v=1 pc=%0d",
                 i, bus.fetch_v_o, bus.fetch_pc_o, i);
      end
    end
  endtask

  task automatic test_random();
    bit rv;
    bit rdy;
    bit rstn;
    int tgt;
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    for (int n = 0; n < 600; n++) begin
      rv   = ($urandom_range(0, 7) == 0);
      rdy  = ($urandom_range(0, 3) != 0);
      rstn = ($urandom_range(0, 63) != 0);
      tgt  = $urandom_range(0, DEPTH - 1);
      step(rv, tgt, rdy, rstn);
      checks++;
      if (bus.fetch_v_o !== (q.size() != 0) || bus.rom_addr_o !== AW'(npc)) begin
        failures++;
        $display("FAIL rand_state[%0d] v=%b addr=%0d want v=%0d addr=%0d",
                 n, bus.fetch_v_o, bus.rom_addr_o, q.size() != 0, npc);
      end
      if (q.size() != 0) begin
        checks++;
        if (bus.fetch_pc_o !== AW'(q[0]) ||
            bus.fetch_instr_o !== rom[q[0]]) begin
          failures++;
          $display("FAIL rand_head[%0d] pc=%0d instr=%0h want pc=%0d instr=%0h",
                   n, bus.fetch_pc_o, bus.fetch_instr_o, q[0], rom[q[0]]);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    npc      = 0;
    reset_n  = 0;
    bus.redirect_v_i  = 0;
    bus.redirect_pc_i = '0;
    bus.fetch_ready_i = 0;
    rom_identity();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
